// File: rtl/mips_cpu_lsu_pkg.sv
// Shared types and helpers for the MIPS load/store unit.
package mips_cpu_lsu_pkg;

  // Operation codes; bit 3 set marks a store.
  typedef enum logic [3:0] {
    LB  = 4'd0,
    LBU = 4'd1,
    LH  = 4'd2,
    LHU = 4'd3,
    LW  = 4'd4,
    LWL = 4'd5,
    LWR = 4'd6,
    SB  = 4'd8,
    SH  = 4'd9,
    SW  = 4'd10
  } lsu_op_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WRITE  = 2'd2,
    S_RESP   = 2'd3
  } lsu_state_t;

  function automatic logic is_store(input lsu_op_t op);
    return op[3];
  endfunction

  // Halfword ops need an even offset, word ops a zero offset; byte and
  // unaligned-word ops (LWL/LWR) are always legal.
  function automatic logic is_misaligned(input lsu_op_t op, input logic [1:0] off);
    return (((op == LH) || (op == LHU) || (op == SH)) && off[0]) ||
           (((op == LW) || (op == SW)) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/mips_cpu_lsu_align.sv
// Combinational lane logic: load extract/extend/merge and store lane merge.
module mips_cpu_lsu_align
  import mips_cpu_lsu_pkg::*;
(
  input  lsu_op_t     op,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  input  logic [31:0] rt,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [4:0]  left_sh;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] lwl_keep;

  // Lane selection; the halfword lane ignores off[0] so odd offsets fall back to the aligned half.
  always_comb begin
    byte_sh    = {off, 3'b000};
    half_sh    = {off[1], 4'b0000};
    left_sh    = {~off, 3'b000};
    byte_v     = 8'(word >> byte_sh);
    half_v     = 16'(word >> half_sh);
    lwl_keep   = ~(32'hFFFF_FFFF << left_sh);
    load_data  = word;
    store_data = wdata;
    case (op)
      LB:      load_data = {{24{byte_v[7]}}, byte_v};
      LBU:     load_data = {24'h0, byte_v};
      LH:      load_data = {{16{half_v[15]}}, half_v};
      LHU:     load_data = {16'h0, half_v};
      LWL:     load_data = (word << left_sh) | (rt & lwl_keep);
      LWR:     load_data = (word >> byte_sh) | (rt & ~(32'hFFFF_FFFF >> byte_sh));
      SB:      store_data = (word & ~(32'h0000_00FF << byte_sh)) |
                            ({24'h0, wdata[7:0]} << byte_sh);
      SH:      store_data = (word & ~(32'h0000_FFFF << half_sh)) |
                            ({16'h0, wdata[15:0]} << half_sh);
      default: begin
        load_data  = word;
        store_data = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mips_cpu_lsu.sv
// MIPS load/store unit: turns CPU requests into aligned word accesses,
// read-modify-write for sub-word stores.
// Optional macro MIPS_CPU_LSU_ALIGN_CHECK_EN: misaligned LH/LHU/SH/LW/SW
// skip memory and respond with resp_err=1.
module mips_cpu_lsu
  import mips_cpu_lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [31:0]       req_rt,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata
);

  lsu_state_t  state_q, state_d;
  lsu_op_t     op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rt_q, rt_d;
  logic [31:0] word_q, word_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] align_word;
  logic [31:0] load_data;
  logic [31:0] store_data;
  logic        misalign_hit;

`ifdef MIPS_CPU_LSU_ALIGN_CHECK_EN
  assign misalign_hit = is_misaligned(op_q, addr_q[1:0]);
`else
  assign misalign_hit = 1'b0;
`endif

  assign mem_address = ADDR_W'({addr_q[31:2], 2'b00});
  assign resp_rdata  = rdata_q;
  assign resp_err    = err_q;

  mips_cpu_lsu_align u_align (
    .op         (op_q),
    .off        (addr_q[1:0]),
    .word       (align_word),
    .rt         (rt_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_data (store_data)
  );

  // Next-state, request capture and memory strobes.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rt_d          = rt_q;
    word_d        = word_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    align_word    = word_q;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_writedata = 32'h0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d    = lsu_op_t'(req_op);
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rt_d    = req_rt;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // Loads are formatted straight from the read bus so the result is
        // already registered when resp_valid rises.
        align_word = mem_readdata;
        err_d      = 1'b0;
        state_d    = S_RESP;
        if (misalign_hit) begin
          err_d = 1'b1;
        end else if (op_q == SW) begin
          mem_write     = 1'b1;
          mem_writedata = wdata_q;
        end else if (is_store(op_q)) begin
          mem_read = 1'b1;
          word_d   = mem_readdata;
          state_d  = S_WRITE;
        end else begin
          mem_read = 1'b1;
          word_d   = mem_readdata;
          rdata_d  = load_data;
        end
      end
      S_WRITE: begin
        mem_write     = 1'b1;
        mem_writedata = store_data;
        state_d       = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and request registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= LB;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rt_q    <= 32'h0;
      word_q  <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rt_q    <= rt_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mips_cpu_lsu.sv
// Self-checking bench for mips_cpu_lsu with a byte-level reference model.
module tb_mips_cpu_lsu;

  localparam int OP_LB = 0, OP_LBU = 1, OP_LH = 2, OP_LHU = 3, OP_LW = 4,
                 OP_LWL = 5, OP_LWR = 6, OP_SB = 8, OP_SH = 9, OP_SW = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr, req_wdata, req_rt;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic        mem_read, mem_write;
  logic [31:0] mem_writedata, mem_readdata;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  int          checks = 0;
  int          failures = 0;
  int          wr_count = 0;
  logic        both_seen = 1'b0;
  logic [31:0] last_wr = 32'h0;
  logic [31:0] exp_rdata = 32'h0;

  always #5 clk = ~clk;

  mips_cpu_lsu #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rt(req_rt),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
  );

  // Data memory: combinational read, write on posedge.
  assign mem_readdata = mem[mem_address[9:2]];
  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_address[9:2]] <= mem_writedata;
      last_wr  <= mem_writedata;
      wr_count <= wr_count + 1;
    end
    if (mem_read && mem_write) both_seen <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_misaligned(input int op, input logic [31:0] a);
`ifdef MIPS_CPU_LSU_ALIGN_CHECK_EN
    int b = int'(a[1:0]);
    if ((op == OP_LH || op == OP_LHU || op == OP_SH) && (b % 2 == 1)) return 1'b1;
    if ((op == OP_LW || op == OP_SW) && b != 0) return 1'b1;
    return 1'b0;
`else
    return (a === 32'hx) && (op < 0);
`endif
  endfunction

  function automatic logic [31:0] ref_load(input int op, input logic [31:0] a,
                                           input logic [31:0] w, input logic [31:0] rt);
    int b = int'(a[1:0]);
    logic [31:0] byte_v = (w >> (8 * b)) & 32'hFF;
    logic [31:0] half_v = (w >> (8 * (b & 2))) & 32'hFFFF;
    case (op)
      OP_LB:   return (byte_v >= 128) ? (byte_v | 32'hFFFF_FF00) : byte_v;
      OP_LBU:  return byte_v;
      OP_LH:   return (half_v >= 32768) ? (half_v | 32'hFFFF_0000) : half_v;
      OP_LHU:  return half_v;
      OP_LWL:  return (w << (8 * (3 - b))) | (rt & ((32'h1 << (8 * (3 - b))) - 32'h1));
      OP_LWR:  return (w >> (8 * b)) | (rt & ~(32'hFFFF_FFFF >> (8 * b)));
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_store(input int op, input logic [31:0] a,
                                            input logic [31:0] w, input logic [31:0] wd);
    logic [7:0] bytes [4];
    int b = int'(a[1:0]);
    int h = b & 2;
    for (int i = 0; i < 4; i++) bytes[i] = w[8*i +: 8];
    if (op == OP_SW) return wd;
    if (op == OP_SB) bytes[b] = wd[7:0];
    if (op == OP_SH) begin
      bytes[h]     = wd[7:0];
      bytes[h + 1] = wd[15:8];
    end
    return {bytes[3], bytes[2], bytes[1], bytes[0]};
  endfunction

  task automatic set_word(input logic [31:0] a, input logic [31:0] w);
    mem[a[9:2]]     = w;
    ref_mem[a[9:2]] = w;
  endtask

  // One full transaction with all checks against the reference model.
  task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rt);
    int          idx = int'(a[9:2]);
    bit          st = (op >= 8);
    bit          mis = ref_misaligned(op, a);
    int          exp_lat = (!mis && (op == OP_SB || op == OP_SH)) ? 3 : 2;
    int          wr0 = wr_count;
    int          n = 0;
    int          guard = 0;
    while (!req_ready && guard < 10) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("ready_before_req", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1;
    req_op    = 4'(op);
    req_addr  = a;
    req_wdata = wd;
    req_rt    = rt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_op    = 4'($urandom_range(15));
    n = 1;
    chk("mem_address", mem_address, {a[31:2], 2'b00});
    chk("mem_read", {31'h0, mem_read}, {31'h0, !mis && op != OP_SW});
    chk("mem_write_access", {31'h0, mem_write}, {31'h0, !mis && op == OP_SW});
    while (!resp_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    if (!st && !mis) exp_rdata = ref_load(op, a, ref_mem[idx], rt);
    if (st && !mis) ref_mem[idx] = ref_store(op, a, ref_mem[idx], wd);
    chk("latency", n, exp_lat);
    chk("resp_rdata", resp_rdata, exp_rdata);
    chk("resp_err", {31'h0, resp_err}, {31'h0, mis});
    chk("mem_word", mem[idx], ref_mem[idx]);
    chk("write_count", wr_count - wr0, (st && !mis) ? 1 : 0);
    @(posedge clk); #1;
    chk("resp_pulse", {31'h0, resp_valid}, 32'h0);
  endtask

  initial begin
    int ops[10] = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR, OP_SB, OP_SH, OP_SW};
    logic [31:0] w0;
    for (int i = 0; i < 256; i++) begin
      w0 = $urandom;
      mem[i] = w0;
      ref_mem[i] = w0;
    end
    rst_n = 1'b0; req_valid = 1'b0; req_op = 4'h0;
    req_addr = 32'h0; req_wdata = 32'h0; req_rt = 32'h0;
    #12;
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err", {31'h0, resp_err}, 32'h0);
    chk("rst_strobes", {30'h0, mem_read, mem_write}, 32'h0);
    chk("rst_addr", mem_address, 32'h0);
    chk("rst_wdata", mem_writedata, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Sign/zero extended byte loads.
    set_word(32'h100, 32'h8077_66F5);
    run_op(OP_LB, 32'h100, 32'h0, 32'h0);
    chk("lb_value", resp_rdata, 32'hFFFF_FFF5);
    run_op(OP_LBU, 32'h103, 32'h0, 32'h0);
    chk("lbu_value", resp_rdata, 32'h0000_0080);

    // Byte store read-modify-write followed by a word load.
    set_word(32'h100, 32'h1122_3344);
    run_op(OP_SB, 32'h101, 32'h0000_00AB, 32'h0);
    chk("sb_writedata", last_wr, 32'h1122_AB44);
    run_op(OP_LW, 32'h100, 32'h0, 32'h0);
    chk("lw_after_sb", resp_rdata, 32'h1122_AB44);

    // Unaligned word merges.
    set_word(32'h100, 32'h4433_2211);
    run_op(OP_LWL, 32'h101, 32'h0, 32'hAABB_CCDD);
    chk("lwl_value", resp_rdata, 32'h2211_CCDD);
    run_op(OP_LWR, 32'h102, 32'h0, 32'hAABB_CCDD);
    chk("lwr_value", resp_rdata, 32'hAABB_4433);

    // Reset during the write phase of a halfword store.
    set_word(32'h108, 32'hDEAD_BEEF);
    w0 = wr_count;
    req_valid = 1'b1; req_op = 4'(OP_SH); req_addr = 32'h10A;
    req_wdata = 32'h0000_1234; req_rt = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("sh_in_write", {31'h0, mem_write}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_mem_write", {31'h0, mem_write}, 32'h0);
    chk("abort_ready", {31'h0, req_ready}, 32'h1);
    chk("abort_resp_valid", {31'h0, resp_valid}, 32'h0);
    exp_rdata = 32'h0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_mem_word", mem[32'h108 >> 2], 32'hDEAD_BEEF);
    chk("abort_no_write", wr_count - w0, 32'h0);
    chk("abort_ready_after", {31'h0, req_ready}, 32'h1);
    chk("abort_rdata", resp_rdata, 32'h0);

    // Misaligned word store.
    set_word(32'h100, 32'h5566_7788);
    run_op(OP_SW, 32'h102, 32'hCAFE_F00D, 32'h0);
`ifdef MIPS_CPU_LSU_ALIGN_CHECK_EN
    chk("sw_mis_word", mem[32'h100 >> 2], 32'h5566_7788);
`else
    chk("sw_mis_word", mem[32'h100 >> 2], 32'hCAFE_F00D);
`endif

    // Randomized mix over a small window so loads see earlier stores.
    for (int k = 0; k < 60; k++) begin
      run_op(ops[$urandom_range(9)], 32'h100 + 32'($urandom_range(63)),
             $urandom, $urandom);
    end

    chk("never_read_and_write", {31'h0, both_seen}, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_cpu_lsu.md
Name: mips_cpu_lsu

Overview:
- Load/store unit directly upstream of the CPU data memory.
- The memory is a little-endian byte array: 32-bit word at `address`, byte `address+0` = bits [7:0]. Writes occur on clk posedge; reads are combinational; there are no byte enables.
- This block turns CPU load/store requests into aligned word accesses. It does read-modify-write for byte and halfword stores, and extracts, extends or merges load data.
- Sits between the execute/memory pipeline stage and the data memory, with a valid/ready handshake toward the CPU.

Parameters:
- ADDR_W, 32, address width presented to memory.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  CPU request present
- req_ready  out  1  block can accept a request this cycle
- req_op  in  4  operation code (see package)
- req_addr  in  32  byte address
- req_wdata  in  32  store data (rt)
- req_rt  in  32  current rt value, used for the LWL/LWR merge
- resp_valid  out  1  one-cycle pulse: access complete
- resp_rdata  out  32  load result, held until the next resp_valid
- resp_err  out  1  misalignment flag, valid with resp_valid
- mem_address  out  32  word-aligned memory address
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_writedata  out  32  memory write data
- mem_readdata  in  32  memory read data (combinational)

Behaviour:
- Reset (rst_n low, async): state=IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; mem_read=0; mem_write=0; mem_address=0; mem_writedata=0.
- Reset asserted mid-operation aborts the operation. Any memory write not yet clocked is dropped.
- Handshake:
  - A request is accepted when req_valid && req_ready.
  - req_ready=1 only in IDLE.
  - op, addr, wdata and rt are captured into registers at acceptance.
  - Inputs are ignored while req_ready=0.
- mem_address = {addr_q[31:2],2'b00}, always. off = addr_q[1:0].
- States: IDLE, ACCESS, WRITE, RESP.
- IDLE: on accept -> ACCESS.
- ACCESS:
  - Loads: mem_read=1; latch mem_readdata into word_q -> RESP.
  - SW: mem_write=1, mem_writedata=wdata_q -> RESP.
  - SB/SH: mem_read=1; latch word_q -> WRITE.
- WRITE:
  - mem_write=1; mem_writedata = word_q with the selected lane(s) replaced.
  - SB: byte lane off gets wdata_q[7:0].
  - SH: lanes off and off+1 get wdata_q[15:0].
  - Next -> RESP.
- RESP: resp_valid=1 for exactly one cycle; resp_rdata updated -> IDLE.
- Latency from accept edge to resp_valid: loads and SW 2 cycles; SB/SH 3 cycles. Back-to-back: the next accept happens in the cycle after RESP.
- mem_read and mem_write are never both 1.
- Load data rules (w = word_q):
  - LB: byte lane off, sign-extended.
  - LBU: byte lane off, zero-extended.
  - LH: bytes off and off+1 (off in {0,2}), sign-extended.
  - LHU: same bytes, zero-extended.
  - LW: w.
  - LWL off=b: result = (w << 8*(3-b)) | (rt_q & ((1<<8*(3-b))-1)).
  - LWR off=b: result = (w >> 8*b) | (rt_q & ~(32'hFFFFFFFF >> 8*b)).
- Without the align check, misaligned LH/LHU/SH (off odd) or LW/SW (off≠0) use the lane arithmetic above on the aligned word: the halfword lane is off&2, and the word is the full word. resp_err=0.
- Store data lane placement is independent of request register reuse. word_q is not visible externally.

Optional Feature:
- Macro: MIPS_CPU_LSU_ALIGN_CHECK_EN.
- Defined:
  - Misaligned LH/LHU/SH (off[0]=1) or LW/SW (off≠0) go ACCESS->RESP with mem_read=0 and mem_write=0.
  - resp_err=1; resp_rdata unchanged.
  - LB/LBU/SB/LWL/LWR are never misaligned.
- Undefined: resp_err tied 0; behaviour as in Behaviour.

Decomposition:
- Package mips_cpu_lsu_pkg:
  - Typedef lsu_op_t (4 bit): LB=0, LBU=1, LH=2, LHU=3, LW=4, LWL=5, LWR=6, SB=8, SH=9, SW=10. op[3] = store.
  - Typedef lsu_state_t.
  - Helper functions is_store and is_misaligned.
- One sub-module, mips_cpu_lsu_align: purely combinational load extract/extend/merge plus store lane merge, unit-testable alone.

Test Plan:
- Memory word @0x100 = 0x8077_66F5; LB addr 0x100 -> resp_rdata=0xFFFF_FFF5, 2 cycles after accept. LBU addr 0x103 -> 0x0000_0080.
- SB wdata=0xAB addr 0x101 over word 0x1122_3344 -> mem_writedata=0x1122_AB44 in WRITE; resp 3 cycles after accept; next LW returns 0x1122_AB44.
- LWL addr 0x101, word 0x4433_2211, rt=0xAABB_CCDD -> 0x2211_CCDD. LWR addr 0x102, same word/rt -> 0xAABB_4433.
- Reset pulse during WRITE of SH -> no mem_write edge; after release req_ready=1, resp_valid=0; memory word unchanged.
- With MIPS_CPU_LSU_ALIGN_CHECK_EN, SW addr 0x102 -> resp_err=1, mem_write never asserted. Without the macro, the same request writes the full word at 0x100.
